// File: rtl/mem_port_arbiter_pkg.sv
// Shared sizes and FSM encoding for the memory-port arbiter.
package mem_port_arbiter_pkg;
  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Fixed LS-over-IF priority select with a saturating starvation counter
// that forces IF ahead once LS has won STARVE_MAX contested grants.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_elig,
  input  logic ls_elig,
  output logic grant_if,
  output logic grant_ls
);
  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] next_starve_cnt;

  always_comb begin
    grant_if        = idle & if_elig & (~ls_elig | (starve_cnt == MAX_CNT));
    grant_ls        = idle & ls_elig & ~grant_if;
    next_starve_cnt = starve_cnt;
    if (grant_if) begin
      next_starve_cnt = '0;
    end else if (grant_ls && if_elig && (starve_cnt != MAX_CNT)) begin
      next_starve_cnt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt <= '0;
    else       starve_cnt <= next_starve_cnt;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// state   | meaning
// IDLE    | no transaction; grant an eligible requester
// BUSY_IF | fetch on the port, waiting for mem_ack
// BUSY_LS | load/store on the port, waiting for mem_ack
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_SIZE,
  parameter int DATA_W     = INSTR_SIZE,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_stall
);
  arb_state_t        state, state_nxt;
  logic              grant_if, grant_ls;
  logic              if_elig, ls_elig;
  logic              mem_req_nxt, mem_we_nxt, if_ack_nxt, ls_ack_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, ls_rdata_nxt;

  // The registered ack masks a requester still holding req in its ack cycle.
  assign if_elig     = if_req & ~if_ack;
  assign ls_elig     = ls_req & ~ls_ack;
  assign fetch_stall = if_req & ~if_ack;

  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
    .clk      (clk),
    .reset    (reset),
    .idle     (state == IDLE),
    .if_elig  (if_elig),
    .ls_elig  (ls_elig),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    ls_rdata_nxt  = ls_rdata;
    if_ack_nxt    = 1'b0;
    ls_ack_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_nxt     = BUSY_LS;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = ls_we;
          mem_addr_nxt  = ls_addr;
          mem_wdata_nxt = ls_wdata;
        end else if (grant_if) begin
          state_nxt    = BUSY_IF;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          if_rdata_nxt = mem_rdata;
          if_ack_nxt   = 1'b1;
        end
      end
      BUSY_LS: begin
        if (mem_ack) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          ls_rdata_nxt = mem_rdata;
          ls_ack_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_ack    <= if_ack_nxt;
      ls_ack    <= ls_ack_nxt;
      if_rdata  <= if_rdata_nxt;
      ls_rdata  <= ls_rdata_nxt;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level arbitration model predicts memory
// requests and acks; a negedge monitor compares them against the DUT.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } mem_t;
  typedef struct packed {
    logic          is_if;
    logic [DW-1:0] d;
  } ack_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ack, ls_req, ls_we, ls_ack;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [DW-1:0] if_rdata, ls_wdata, ls_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, fetch_stall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  // issued transactions (written by stimulus only)
  logic [AW-1:0] if_arr[0:255];
  logic [AW-1:0] ls_addr_arr[0:255];
  logic [DW-1:0] ls_wd_arr[0:255];
  logic          ls_we_arr[0:255];
  int            if_iss = 0, ls_iss = 0, if_to = 0, ls_to = 0;
  int            resp_lat = -1, spur_cnt = 0;
  bit            resp_en = 1'b1, final_check = 1'b0;

  mem_t mq[$];
  ack_t aq[$];
  int   checks = 0, errors = 0;
  bit   done = 1'b0;

  // reference model state (written by the model process only)
  int            if_srv = 0, ls_srv = 0, starve = 0;
  bit            busy = 1'b0, cur_if = 1'b0, rst_edge = 1'b0;
  logic [DW-1:0] last_wd = '0;

  initial begin
    bit ife, lse;
    forever begin
      @(posedge clk);
      rst_edge = reset;
      if (reset) begin
        busy = 1'b0; starve = 0; last_wd = '0;
        if_srv = if_iss; ls_srv = ls_iss;
      end else if (busy) begin
        if (mem_ack) begin
          busy = 1'b0;
          aq.push_back(ack_t'{cur_if, mem_rdata});
        end
      end else begin
        ife = (if_iss > if_srv);
        lse = (ls_iss > ls_srv);
        if (ife && (!lse || starve == SMAX)) begin
          mq.push_back(mem_t'{1'b0, if_arr[if_srv], last_wd});
          if_srv++; starve = 0; cur_if = 1'b1; busy = 1'b1;
        end else if (lse) begin
          mq.push_back(mem_t'{ls_we_arr[ls_srv], ls_addr_arr[ls_srv], ls_wd_arr[ls_srv]});
          last_wd = ls_wd_arr[ls_srv];
          ls_srv++; cur_if = 1'b0; busy = 1'b1;
          if (ife && starve < SMAX) starve++;
        end
      end
    end
  end

  // memory responder
  initial begin
    int lat;
    int spur_done = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_done) begin
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1 mem_ack = 1'b0;
        spur_done++;
      end else if (resp_en && mem_req) begin
        lat = (resp_lat < 0) ? int'($urandom_range(0, 3)) : resp_lat;
        repeat (lat) @(posedge clk);
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1 mem_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic prev_req = 1'b0;
    mem_t cur = '0;
    ack_t a;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {if_ack, ls_ack}, 0);
        chk("rst_rdata", if_rdata | ls_rdata, 0);
      end
      if (mem_req && !prev_req) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req_unexpected actual=1 required=0");
        end else begin
          cur = mq.pop_front();
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", mem_wdata, cur.wd);
        end
      end else if (mem_req) begin
        chk("mem_addr_hold", mem_addr, cur.addr);
      end
      if (if_ack && ls_ack) begin
        checks++; errors++;
        $display("FAIL both_acks actual=11 required=one");
      end else if (if_ack || ls_ack) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected actual if_ack=%0b ls_ack=%0b required=none", if_ack, ls_ack);
        end else begin
          a = aq.pop_front();
          chk("ack_source_if", if_ack, a.is_if);
          chk("ack_rdata", if_ack ? if_rdata : ls_rdata, a.d);
        end
      end
      chk("fetch_stall", fetch_stall, if_req & ~if_ack);
      prev_req = mem_req;
      if (final_check && !done) begin
        chk("mem_queue_drained", mq.size(), 0);
        chk("ack_queue_drained", aq.size(), 0);
        chk("if_timeouts", if_to, 0);
        chk("ls_timeouts", ls_to, 0);
        done = 1'b1;
      end
    end
  end

  task automatic do_if(input int n, input int maxgap, input bit fixed, input logic [AW-1:0] base);
    int gap, t;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, maxgap);
      if (gap > 0) if_req = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      if_addr = fixed ? base + AW'(4 * i) : AW'($urandom);
      if_arr[if_iss] = if_addr;
      if_req = 1'b1;
      if_iss++;
      t = 0;
      do begin @(negedge clk); t++; end while (!if_ack && t < 500);
      if (!if_ack) if_to++;
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  task automatic do_ls(input int n, input int maxgap, input bit fixed, input logic [AW-1:0] base,
                       input logic we, input logic [DW-1:0] wd);
    int gap, t;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, maxgap);
      if (gap > 0) ls_req = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      ls_addr  = fixed ? base + AW'(4 * i) : AW'($urandom);
      ls_we    = fixed ? we : 1'($urandom);
      ls_wdata = fixed ? wd : DW'($urandom);
      ls_addr_arr[ls_iss] = ls_addr;
      ls_we_arr[ls_iss]   = ls_we;
      ls_wd_arr[ls_iss]   = ls_wdata;
      ls_req = 1'b1;
      ls_iss++;
      t = 0;
      do begin @(negedge clk); t++; end while (!ls_ack && t < 500);
      if (!ls_ack) ls_to++;
      @(posedge clk); #1;
    end
    ls_req = 1'b0;
  endtask

  initial begin
    int t;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single fetch, ack two cycles after mem_req
    resp_lat = 1;
    do_if(1, 0, 1'b1, 32'h4);

    // simultaneous requests: store wins first
    fork
      do_if(1, 0, 1'b1, 32'h200);
      do_ls(1, 0, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF);
    join

    // both held back-to-back
    resp_lat = 0;
    fork
      do_if(4, 0, 1'b1, 32'h1000);
      do_ls(10, 0, 1'b1, 32'h2000, 1'b0, 32'h0);
    join

    // reset while a load is on the port, then a late mem_ack
    resp_en = 1'b0;
    ls_addr = 32'h300; ls_we = 1'b0; ls_wdata = 32'h55;
    ls_addr_arr[ls_iss] = ls_addr; ls_we_arr[ls_iss] = ls_we; ls_wd_arr[ls_iss] = ls_wdata;
    ls_req = 1'b1; ls_iss++;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_req && t < 50);
    if (!mem_req) ls_to++;
    @(posedge clk); #1 reset = 1'b1; ls_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0; spur_cnt++;
    repeat (6) @(posedge clk);
    #1;

    // spurious mem_ack in idle with no requests
    spur_cnt++;
    repeat (6) @(posedge clk);
    #1;

    // randomized traffic
    resp_en = 1'b1; resp_lat = -1;
    fork
      do_if(40, 3, 1'b0, 32'h0);
      do_ls(40, 3, 1'b0, 32'h0, 1'b0, 32'h0);
    join

    repeat (10) @(posedge clk);
    final_check = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch stage and the load/store stage.
- Runs one outstanding transaction at a time through a small FSM. Load/store has fixed priority, with a starvation counter that guarantees fetch progress.
- Generates the fetch-stage stall while an instruction fetch is pending.
- Sits between the fetch/mem pipeline stages and the external memory interface.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- STARVE_MAX, 4, number of consecutive LS grants made while IF is waiting before IF is forced ahead; legal range 1..15.

Ports:
- clk  input  1  clock, all state on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- if_req  input  1  fetch read request; held until if_ack.
- if_addr  input  ADDR_W  fetch address, stable while if_req is high.
- if_ack  output  1  one-cycle pulse: fetch transaction complete.
- if_rdata  output  DATA_W  fetched word, valid when if_ack is high.
- ls_req  input  1  load/store request; held until ls_ack.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_ack  output  1  one-cycle pulse: LS transaction complete.
- ls_rdata  output  DATA_W  load data, valid when ls_ack is high (store: last captured word).
- mem_req  output  1  memory request, held until mem_ack is sampled.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ack  input  1  memory completion, qualifies mem_rdata.
- mem_rdata  input  DATA_W  memory read data.
- fetch_stall  output  1  combinational: if_req & ~if_ack; drives the fetch stage stall input.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_LS. All outputs are registered except fetch_stall.
- Reset (synchronous): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ack=0, ls_ack=0, if_rdata=0, ls_rdata=0; starve_cnt=0.
- Reset mid-transaction: mem_req drops at that edge and no ack is issued. Any later mem_ack arriving in IDLE is ignored.
- Eligibility in IDLE:
  - IF is eligible when if_req=1 and if_ack=0.
  - LS is eligible when ls_req=1 and ls_ack=0.
  - This mask blocks a re-issue in the cycle a requester is still seeing its ack.
- Grant in IDLE:
  - Only LS eligible -> LS.
  - Only IF eligible -> IF.
  - Both eligible -> LS, unless starve_cnt==STARVE_MAX, in which case IF.
- On grant (same edge):
  - Latch mem_addr, mem_we (0 for IF), and mem_wdata (held at previous value for IF).
  - Set mem_req=1 and move to BUSY_IF or BUSY_LS.
  - Latency: request sampled at edge N -> mem_req high from N+1.
- BUSY_x: outputs are held stable. On the edge where mem_ack=1:
  - mem_req <= 0.
  - x_rdata <= mem_rdata.
  - x_ack <= 1 for exactly one cycle.
  - state <= IDLE.
- Back-to-back: mem_req is low for at least one cycle between transactions. The minimum transaction is 3 cycles (grant edge, ack edge, idle).
- mem_ack while mem_req=0: ignored.
- Starvation counter:
  - LS granted while IF eligible -> starve_cnt+1, saturating at STARVE_MAX.
  - IF granted -> starve_cnt=0.
  - LS granted while IF not eligible -> unchanged.
- Requester inputs are only sampled at the grant edge; later changes do not affect mem_*.

Decomposition:
- ADDR_W/DATA_W defaults come from the shared params include (ADDR_SIZE, INSTR_SIZE).
- State encodings IDLE=2'd0, BUSY_IF=2'd1, BUSY_LS=2'd2 are defined in the same include.
- One sub-module is natural: arb_prio_sel. It takes the two eligible bits plus starve_cnt and outputs grant_if, grant_ls and next_starve_cnt (combinational select plus the registered counter).

Test Plan:
- Reset, then if_req=1, if_addr=0x4, mem_ack arriving 2 cycles after mem_req -> mem_req high 1 cycle after the request for 2 cycles, mem_addr=0x4, mem_we=0; if_ack pulses once with if_rdata=mem_rdata; fetch_stall=1 until the if_ack cycle, then 0.
- if_req and ls_req (store, addr 0x100, wdata 0xDEADBEEF) rise in the same cycle -> LS served first with mem_we=1, mem_wdata=0xDEADBEEF; IF served in the next transaction.
- ls_req held continuously with new addresses after each ack, if_req held, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS...; starve_cnt returns to 0 after the IF grant.
- Requester holds req during its ack cycle -> no second mem_req is issued for it; mem_req is low for at least 1 cycle between transactions.
- reset asserted while in BUSY_LS with mem_req=1 -> mem_req=0 at the next edge, ls_ack never pulses, and a mem_ack arriving 1 cycle later is ignored.
- Spurious mem_ack=1 in IDLE with no requests -> no ack outputs; state remains IDLE.
